// File: rtl/sseg_display_arbiter.sv
// sseg_display_arbiter
//   Shares one 4-digit seven-segment display between NREQ requesters.
//   Requesters are served round robin. An owner keeps the display for at
//   least HOLD_CYCLES while others contend. Between owners the display is
//   blanked for GAP_CYCLES cycles.
//
// Ports
//   clk        in   1        clock, rising edge
//   rst        in   1        asynchronous active-high reset
//   req        in   NREQ     level request per requester
//   data       in   16*NREQ  requester i digits at data[16*i +: 16], {d3,d2,d1,d0}
//   grant      out  NREQ     one-hot (or zero) current owner, registered
//   busy       out  1        high whenever the FSM is not IDLE
//   d3..d0     out  4 each   hex digits to the display driver, registered
//   state_dbg  out  2        current FSM state (0 IDLE, 1 OWN, 2 GAP)
//
// Handshake: req is a level. A requester owns the display while its grant
// bit is high. Dropping req releases the display at the next edge,
// whatever the remaining hold time.
module sseg_display_arbiter #(
    parameter int          NREQ        = 3,
    parameter int          HOLD_CYCLES = 8,
    parameter int          GAP_CYCLES  = 2,
    parameter logic [15:0] BLANK_VAL   = 16'h0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [16*NREQ-1:0] data,
    output logic [NREQ-1:0]   grant,
    output logic              busy,
    output logic [3:0]        d3,
    output logic [3:0]        d2,
    output logic [3:0]        d1,
    output logic [3:0]        d0,
    output logic [1:0]        state_dbg
);

    localparam int CMAX = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int LW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN  = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [LW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   hold_q, hold_d;
    logic [CW-1:0]   gap_q, gap_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [15:0]     digits_q, digits_d;

    logic [LW-1:0]   win;
    logic            win_found;
    logic [NREQ-1:0] owner_onehot;
    logic            others_req;

    // Round-robin pick: scan from owner+1 upward with wrap. The current
    // owner is examined last, so it only wins again when nobody else asks.
    always_comb begin
        win       = owner_q;
        win_found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            if (!win_found && req[(int'(owner_q) + i) % NREQ]) begin
                win       = LW'((int'(owner_q) + i) % NREQ);
                win_found = 1'b1;
            end
        end
    end

    assign owner_onehot = NREQ'(1) << owner_q;
    assign others_req   = |(req & ~owner_onehot);

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        grant_d  = '0;
        digits_d = BLANK_VAL;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d  = OWN;
                    owner_d  = win;
                    hold_d   = CW'(HOLD_CYCLES - 1);
                    grant_d  = NREQ'(1) << win;
                    digits_d = data[16*int'(win) +: 16];
                end
            end
            OWN: begin
                // An owner drop always forces the blank gap, even if other
                // requests are already waiting.
                if (!req[owner_q] || (hold_q == '0 && others_req)) begin
                    state_d = GAP;
                    gap_d   = CW'(GAP_CYCLES - 1);
                end else begin
                    grant_d  = owner_onehot;
                    digits_d = data[16*int'(owner_q) +: 16];
                    if (hold_q != '0) begin
                        hold_d = hold_q - CW'(1);
                    end
                end
            end
            GAP: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - CW'(1);
                end else if (win_found) begin
                    state_d  = OWN;
                    owner_d  = win;
                    hold_d   = CW'(HOLD_CYCLES - 1);
                    grant_d  = NREQ'(1) << win;
                    digits_d = data[16*int'(win) +: 16];
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            owner_q  <= LW'(NREQ - 1);
            hold_q   <= '0;
            gap_q    <= '0;
            grant_q  <= '0;
            digits_q <= BLANK_VAL;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            hold_q   <= hold_d;
            gap_q    <= gap_d;
            grant_q  <= grant_d;
            digits_q <= digits_d;
        end
    end

    assign grant            = grant_q;
    assign busy             = (state_q != IDLE);
    assign {d3, d2, d1, d0} = digits_q;
    assign state_dbg        = state_q;

endmodule

// File: tb/tb_sseg_display_arbiter.sv
module tb_sseg_display_arbiter;

    localparam int NREQ = 3;
    localparam int HOLD = 8;
    localparam int GAPC = 2;
    localparam logic [15:0] BLANK = 16'h0000;

    // clock / reset
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  req = '0;
    logic [47:0] data = '0;
    logic [2:0]  grant;
    logic        busy;
    logic [3:0]  d3, d2, d1, d0;
    logic [1:0]  state_dbg;

    always #5 clk = ~clk;

    sseg_display_arbiter #(
        .NREQ(NREQ), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAPC), .BLANK_VAL(BLANK)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .data(data), .grant(grant), .busy(busy),
        .d3(d3), .d2(d2), .d1(d1), .d0(d0), .state_dbg(state_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: tracks who owns the display, how long it has held
    // it, and how many blank cycles remain, straight from the rules.
    int          m_mode;      // 0 idle, 1 owned, 2 blank gap
    int          m_last;
    int          m_held;
    int          m_gap_left;
    logic [2:0]  m_grant;
    logic [15:0] m_dig;

    function automatic int rr_pick(input int last, input logic [2:0] r);
        int idx;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (last + i) % NREQ;
            if (r[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_last = NREQ - 1; m_held = 0; m_gap_left = 0;
        m_grant = '0; m_dig = BLANK;
    endtask

    task automatic model_take(input int w);
        if (w >= 0) begin
            m_mode = 1; m_last = w; m_held = 1;
        end else begin
            m_mode = 0;
        end
    endtask

    task automatic model_step();
        case (m_mode)
            0: model_take(rr_pick(m_last, req));
            1: begin
                if (!req[m_last] || (m_held >= HOLD && (req & ~(3'b001 << m_last)) != 3'b000)) begin
                    m_mode = 2; m_gap_left = GAPC;
                end else begin
                    m_held++;
                end
            end
            default: begin
                m_gap_left--;
                if (m_gap_left == 0) model_take(rr_pick(m_last, req));
            end
        endcase
        if (m_mode == 1) begin
            m_grant = 3'b001 << m_last;
            m_dig   = data[16*m_last +: 16];
        end else begin
            m_grant = '0;
            m_dig   = BLANK;
        end
    endtask

    // driver: one clock, model stepped on the same sampled inputs, outputs
    // compared 1 time unit after the edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check("model_grant", {61'd0, grant}, {61'd0, m_grant});
        check("model_busy", {63'd0, busy}, {63'd0, (m_mode != 0)});
        check("model_digits", {48'd0, d3, d2, d1, d0}, {48'd0, m_dig});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_grant", {61'd0, grant}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_digits", {48'd0, d3, d2, d1, d0}, {48'd0, BLANK});
        rst = 1'b0;
    endtask

    typedef struct {
        logic [2:0]  req;
        logic [47:0] data;
        logic [2:0]  grant;
        logic        busy;
        logic [15:0] dig;
    } vec_t;

    vec_t vt[9];

    logic [2:0] exp_g;

    initial begin
        // T1 then T4 (owner drops on 3rd owned cycle), then a fresh owner
        vt[0] = '{3'b001, {16'h0, 16'h0, 16'h1234}, 3'b001, 1'b1, 16'h1234};
        vt[1] = '{3'b001, {16'h0, 16'h0, 16'hABCD}, 3'b001, 1'b1, 16'hABCD};
        vt[2] = '{3'b001, {16'h0, 16'h0, 16'hABCD}, 3'b001, 1'b1, 16'hABCD};
        vt[3] = '{3'b000, {16'h0, 16'h0, 16'hABCD}, 3'b000, 1'b1, 16'h0000};
        vt[4] = '{3'b000, {16'h0, 16'h0, 16'hABCD}, 3'b000, 1'b1, 16'h0000};
        vt[5] = '{3'b000, {16'h0, 16'h0, 16'hABCD}, 3'b000, 1'b0, 16'h0000};
        vt[6] = '{3'b010, {16'h0, 16'h5678, 16'h0}, 3'b010, 1'b1, 16'h5678};
        vt[7] = '{3'b010, {16'h0, 16'h5678, 16'h0}, 3'b010, 1'b1, 16'h5678};
        vt[8] = '{3'b110, {16'h9999, 16'h5678, 16'h0}, 3'b010, 1'b1, 16'h5678};

        do_reset();
        for (int i = 0; i < 9; i++) begin
            req  = vt[i].req;
            data = vt[i].data;
            @(posedge clk);
            model_step();
            #1;
            check($sformatf("vec%0d_grant", i), {61'd0, grant}, {61'd0, vt[i].grant});
            check($sformatf("vec%0d_busy", i), {63'd0, busy}, {63'd0, vt[i].busy});
            check($sformatf("vec%0d_digits", i), {48'd0, d3, d2, d1, d0}, {48'd0, vt[i].dig});
        end

        // T2: req0 and req2 together from reset
        do_reset();
        req  = 3'b101;
        data = {16'hC0C0, 16'h0, 16'h0A0A};
        for (int k = 0; k < 11; k++) begin
            cycle();
            exp_g = (k < 8) ? 3'b001 : (k < 10) ? 3'b000 : 3'b100;
            check($sformatf("t2_grant_k%0d", k), {61'd0, grant}, {61'd0, exp_g});
        end

        // T3: all three held, full rotation
        do_reset();
        req  = 3'b111;
        data = {16'h2222, 16'h1111, 16'h0000};
        for (int k = 0; k < 41; k++) begin
            cycle();
            exp_g = ((k % 10) < 8) ? (3'b001 << ((k / 10) % 3)) : 3'b000;
            check($sformatf("t3_grant_k%0d", k), {61'd0, grant}, {61'd0, exp_g});
        end

        // T5: sole owner keeps the display, then contention with expired hold
        do_reset();
        req  = 3'b001;
        data = {16'h0, 16'h7777, 16'h5555};
        for (int k = 0; k < 50; k++) cycle();
        check("t5_sole_owner", {61'd0, grant}, 64'd1);
        req = 3'b011;
        cycle();
        check("t5_gap1", {61'd0, grant}, 64'd0);
        cycle();
        check("t5_gap2", {48'd0, d3, d2, d1, d0}, {48'd0, BLANK});
        cycle();
        check("t5_next_owner", {61'd0, grant}, 64'd2);
        check("t5_next_digits", {48'd0, d3, d2, d1, d0}, 64'h7777);

        // T6: asynchronous reset between edges while owned
        do_reset();
        req  = 3'b001;
        data = {16'h0, 16'h4321, 16'hBEEF};
        repeat (3) cycle();
        #3;
        rst = 1'b1;
        #1;
        check("t6_async_grant", {61'd0, grant}, 64'd0);
        check("t6_async_digits", {48'd0, d3, d2, d1, d0}, {48'd0, BLANK});
        check("t6_async_busy", {63'd0, busy}, 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        req = 3'b010;
        cycle();
        check("t6_after_grant", {61'd0, grant}, 64'd2);

        // randomized traffic against the model
        do_reset();
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 3) == 0) req = 3'($urandom_range(0, 7));
            data = {16'($urandom), 16'($urandom), 16'($urandom)};
            cycle();
            check("rand_onehot", {63'd0, ($countones(grant) <= 1)}, 64'd1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
